// File: rtl/writeback_arbiter_if.sv
// Write-back bus bundle: ALU result request, load-return request and the
// registered register-file write port.
interface writeback_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_addr;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;

  logic [NUM_REGS-1:0]   wr_enable;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [1:0]            fifo_count;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready,
    input  wr_enable, wr_addr, wr_data, fifo_count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready,
    output wr_enable, wr_addr, wr_data, fifo_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: merges ALU results and queued load returns into one
// registered register-file write per cycle with a one-hot enable.
module writeback_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clock,
  input  logic               reset,
  writeback_arbiter_if.slave bus
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [1:0]            q_valid;
  logic [ADDR_WIDTH-1:0] q_addr [2];
  logic [DATA_WIDTH-1:0] q_data [2];
  logic [1:0]            n_valid;
  logic [ADDR_WIDTH-1:0] n_addr [2];
  logic [DATA_WIDTH-1:0] n_data [2];

  logic [3:0]            starve_cnt;
  logic [3:0]            starve_nxt;
  logic [1:0]            count;

  logic                  alu_ready_i;
  logic                  mem_ready_i;
  logic                  grant_alu;
  logic                  grant_mem;
  logic                  push;
  logic                  squash0;
  logic                  squash1;
  logic                  keep0;
  logic                  keep1;

  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;
  logic [NUM_REGS-1:0]   g_onehot;

  logic [NUM_REGS-1:0]   wr_enable_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  // Slot 0 is always the head; entries are kept compacted toward slot 0.
  assign count       = 2'(q_valid[0]) + 2'(q_valid[1]);
  assign mem_ready_i = (count < 2'd2);
  assign alu_ready_i = !(starve_cnt >= 4'(STARVE_LIMIT));

  assign grant_alu = bus.alu_valid & alu_ready_i;
  assign grant_mem = !grant_alu & q_valid[0];
  assign push      = bus.mem_valid & mem_ready_i;

  assign squash0 = grant_alu & q_valid[0] & (q_addr[0] == bus.alu_addr);
  assign squash1 = grant_alu & q_valid[1] & (q_addr[1] == bus.alu_addr);
  assign keep0   = q_valid[0] & !grant_mem & !squash0;
  assign keep1   = q_valid[1] & !squash1;

  // Survivors compact first, then the incoming load is appended behind them.
  always_comb begin
    n_valid = 2'b00;
    n_addr  = q_addr;
    n_data  = q_data;
    if (keep0) begin
      n_valid[0] = 1'b1;
      n_addr[0]  = q_addr[0];
      n_data[0]  = q_data[0];
    end
    if (keep1) begin
      if (keep0) begin
        n_valid[1] = 1'b1;
        n_addr[1]  = q_addr[1];
        n_data[1]  = q_data[1];
      end else begin
        n_valid[0] = 1'b1;
        n_addr[0]  = q_addr[1];
        n_data[0]  = q_data[1];
      end
    end
    if (push) begin
      if (n_valid[0]) begin
        n_valid[1] = 1'b1;
        n_addr[1]  = bus.mem_addr;
        n_data[1]  = bus.mem_data;
      end else begin
        n_valid[0] = 1'b1;
        n_addr[0]  = bus.mem_addr;
        n_data[0]  = bus.mem_data;
      end
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (!q_valid[0] || grant_mem) begin
      starve_nxt = 4'd0;
    end else if (grant_alu && starve_cnt != 4'hF) begin
      starve_nxt = starve_cnt + 4'd1;
    end
  end

  always_comb begin
    g_addr = q_addr[0];
    g_data = q_data[0];
    if (grant_alu) begin
      g_addr = bus.alu_addr;
      g_data = bus.alu_data;
    end
  end

  // x0 is hardwired: a write to it is consumed but raises no enable.
  always_comb begin
    g_onehot = '0;
    if (g_addr != '0) begin
      g_onehot[g_addr] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_valid    <= 2'b00;
      q_addr[0]  <= '0;
      q_addr[1]  <= '0;
      q_data[0]  <= '0;
      q_data[1]  <= '0;
      starve_cnt <= 4'd0;
    end else begin
      q_valid    <= n_valid;
      q_addr     <= n_addr;
      q_data     <= n_data;
      starve_cnt <= starve_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_enable_q <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else if (grant_alu || grant_mem) begin
      wr_enable_q <= g_onehot;
      wr_addr_q   <= g_addr;
      wr_data_q   <= g_data;
    end else begin
      wr_enable_q <= '0;
    end
  end

  assign bus.alu_ready  = alu_ready_i;
  assign bus.mem_ready  = mem_ready_i;
  assign bus.fifo_count = count;
  assign bus.wr_enable  = wr_enable_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a queue-based model.
module tb_writeback_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 32;
  localparam int LIMIT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  writeback_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  int            m_starve;
  logic [NR-1:0] m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] dec(logic [AW-1:0] a);
    logic [NR-1:0] one;
    one = 1;
    return (a == 0) ? '0 : (one << a);
  endfunction

  // Advances the model by one edge using the inputs presented before it.
  task automatic model_step();
    bit alu_rdy, mem_rdy, ga, gm;
    int n_starve;
    if (reset) begin
      mq.delete();
      m_starve = 0;
      m_en     = '0;
      m_addr   = '0;
      m_data   = '0;
      return;
    end
    alu_rdy = (m_starve < LIMIT);
    mem_rdy = (mq.size() < 2);
    ga = bus.alu_valid && alu_rdy;
    gm = !ga && (mq.size() > 0);
    if (mq.size() == 0 || gm) n_starve = 0;
    else if (ga)              n_starve = (m_starve < 15) ? m_starve + 1 : 15;
    else                      n_starve = m_starve;
    if (ga) begin
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].addr == bus.alu_addr) mq.delete(i);
      m_en   = dec(bus.alu_addr);
      m_addr = bus.alu_addr;
      m_data = bus.alu_data;
    end else if (gm) begin
      ent_t e;
      e = mq.pop_front();
      m_en   = dec(e.addr);
      m_addr = e.addr;
      m_data = e.data;
    end else begin
      m_en = '0;
    end
    if (bus.mem_valid && mem_rdy) begin
      ent_t n;
      n.addr = bus.mem_addr;
      n.data = bus.mem_data;
      mq.push_back(n);
    end
    m_starve = n_starve;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    model_step();
  endtask

  task automatic drive(bit av, logic [AW-1:0] aa, logic [DW-1:0] ad,
                       bit mv, logic [AW-1:0] ma, logic [DW-1:0] md);
    bus.alu_valid = av;
    bus.alu_addr  = aa;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_addr  = ma;
    bus.mem_data  = md;
    step();
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("m_wr_enable",  64'(bus.wr_enable),  64'(m_en));
      chk("m_wr_addr",    64'(bus.wr_addr),    64'(m_addr));
      chk("m_wr_data",    64'(bus.wr_data),    64'(m_data));
      chk("m_fifo_count", 64'(bus.fifo_count), 64'(mq.size()));
      chk("m_mem_ready",  64'(bus.mem_ready),  64'(mq.size() < 2));
      chk("m_alu_ready",  64'(bus.alu_ready),  64'(m_starve < LIMIT));
      chk("m_onehot",     64'($countones(bus.wr_enable) <= 1), 64'd1);
    end
  end

  initial begin
    bus.alu_valid = 1'b0;
    bus.alu_addr  = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cmp_en = 1'b1;

    chk("rst_wr_enable",  64'(bus.wr_enable),  64'd0);
    chk("rst_wr_addr",    64'(bus.wr_addr),    64'd0);
    chk("rst_wr_data",    64'(bus.wr_data),    64'd0);
    chk("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
    chk("rst_mem_ready",  64'(bus.mem_ready),  64'd1);
    chk("rst_alu_ready",  64'(bus.alu_ready),  64'd1);

    // ALU-only write
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    chk("alu_wr_enable", 64'(bus.wr_enable), 64'h20);
    chk("alu_wr_data",   64'(bus.wr_data),   64'hDEADBEEF);
    idle();
    chk("alu_pulse_end", 64'(bus.wr_enable), 64'd0);

    // Load path
    drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h12345678);
    chk("ld_count1",    64'(bus.fifo_count), 64'd1);
    chk("ld_no_enable", 64'(bus.wr_enable),  64'd0);
    idle();
    chk("ld_wr_enable", 64'(bus.wr_enable),  64'h80);
    chk("ld_wr_data",   64'(bus.wr_data),    64'h12345678);
    chk("ld_count0",    64'(bus.fifo_count), 64'd0);

    // Full FIFO under continuous ALU pressure
    drive(1'b1, 5'd3, 32'hA0, 1'b1, 5'd10, 32'h1010);
    drive(1'b1, 5'd3, 32'hA1, 1'b1, 5'd11, 32'h1111);
    chk("full_mem_ready", 64'(bus.mem_ready),  64'd0);
    chk("full_count",     64'(bus.fifo_count), 64'd2);
    drive(1'b1, 5'd3, 32'hA2, 1'b0, '0, '0);
    drive(1'b1, 5'd3, 32'hA3, 1'b0, '0, '0);
    chk("starve_alu_rdy_hi", 64'(bus.alu_ready), 64'd1);
    drive(1'b1, 5'd3, 32'hA4, 1'b0, '0, '0);
    chk("starve_alu_rdy_lo", 64'(bus.alu_ready), 64'd0);
    drive(1'b1, 5'd3, 32'hA5, 1'b0, '0, '0);
    chk("starve_pop_enable", 64'(bus.wr_enable),  64'h400);
    chk("starve_pop_data",   64'(bus.wr_data),    64'h1010);
    chk("starve_alu_rdy_back", 64'(bus.alu_ready), 64'd1);
    chk("starve_count",      64'(bus.fifo_count), 64'd1);
    idle();
    idle();
    chk("drain_count", 64'(bus.fifo_count), 64'd0);

    // Squash a queued load with a younger ALU write
    drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h0BAD0BAD);
    drive(1'b1, 5'd9, 32'h600D600D, 1'b0, '0, '0);
    chk("sq_enable", 64'(bus.wr_enable),  64'h200);
    chk("sq_data",   64'(bus.wr_data),    64'h600D600D);
    chk("sq_count",  64'(bus.fifo_count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("sq_no_load_pulse", 64'(bus.wr_enable), 64'd0);
    end

    // Register 0 writes from both sources
    drive(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
    chk("r0_alu_enable", 64'(bus.wr_enable),  64'd0);
    chk("r0_count1",     64'(bus.fifo_count), 64'd1);
    idle();
    chk("r0_ld_enable",  64'(bus.wr_enable),  64'd0);
    chk("r0_count0",     64'(bus.fifo_count), 64'd0);

    // Reset with two loads queued
    drive(1'b1, 5'd2, 32'hB0, 1'b1, 5'd4, 32'h44);
    drive(1'b1, 5'd2, 32'hB1, 1'b1, 5'd5, 32'h55);
    chk("pre_rst_count", 64'(bus.fifo_count), 64'd2);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("mid_rst_count",     64'(bus.fifo_count), 64'd0);
    chk("mid_rst_mem_ready", 64'(bus.mem_ready),  64'd1);
    chk("mid_rst_alu_ready", 64'(bus.alu_ready),  64'd1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("mid_rst_no_pulse", 64'(bus.wr_enable), 64'd0);
    end

    // Randomized traffic; narrow address range makes squashes frequent
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 99) < 60),
            AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, NR - 1) : $urandom_range(0, 5)),
            DW'($urandom),
            ($urandom_range(0, 99) < 50),
            AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, NR - 1) : $urandom_range(0, 5)),
            DW'($urandom));
    end
    reset = 1'b0;
    idle();
    idle();
    @(negedge clock);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Write-back stage that sits directly upstream of the register-file flip-flop bank. It merges two write sources into one registered write per cycle, then decodes that write into a one-hot per-register enable. The two sources are the single-cycle ALU result path and completed memory loads, which arrive asynchronously through a valid/ready handshake. Loads are held in a 2-entry FIFO, and a starvation counter guarantees loads eventually retire.

## Interface
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose to the ALU before ALU is stalled (1..15)

- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU write request
- alu_ready  out  1  ALU write accepted this cycle when alu_valid & alu_ready
- alu_addr  in  ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- mem_valid  in  1  load-return write request
- mem_ready  out  1  FIFO can accept a load this cycle
- mem_addr  in  ADDR_WIDTH  load destination register
- mem_data  in  DATA_WIDTH  load data
- wr_enable  out  NUM_REGS  one-hot per-register enable, registered
- wr_addr  out  ADDR_WIDTH  committed register index, registered
- wr_data  out  DATA_WIDTH  committed data, registered, common to all registers
- fifo_count  out  2  load entries currently queued (0..2)

## Operation
- Load FIFO: 2 entries, each holding {valid, addr, data}.
  - Push on mem_valid & mem_ready.
  - mem_ready = (fifo_count < 2), computed from the registered count only; a pop in the same cycle does not free space early.
- Starve counter: 4 bits, saturating.
  - Increments each cycle the FIFO holds a valid head and the ALU is granted.
  - Clears on any FIFO pop or when the FIFO is empty.
- alu_ready = !(starve counter >= STARVE_LIMIT).
- Grant, evaluated once per cycle:
  1. If alu_valid & alu_ready: grant the ALU.
  2. Otherwise, if the FIFO head is valid: grant the FIFO head and pop it.
  3. Otherwise: no grant.
- Squash: when the ALU is granted with address A, every FIFO entry already queued with addr == A is invalidated (the ALU result is younger).
  - The entry is removed and fifo_count decrements.
  - A load pushed in the same cycle is not squashed.
- Register 0: a granted write to address 0 is consumed normally, but wr_enable stays all-zero. x0 is never written.
- Decode: on a grant, the next cycle drives wr_enable[addr] = 1 with all other bits 0, plus wr_addr and wr_data. With no grant, wr_enable = 0; wr_addr and wr_data hold their previous values.

## Timing
- Reset values (cycle after a reset edge): wr_enable = 0, wr_addr = 0, wr_data = 0, fifo_count = 0, starve counter = 0, all FIFO valid bits = 0. After reset, mem_ready = 1 and alu_ready = 1.
- Reset mid-operation discards queued loads without writing them.
- ALU latency: accepted at edge N → wr_enable is high for cycle N..N+1 → the register flop captures at edge N+1.
- Load latency: pushed at edge N → earliest wr_enable is in cycle N+1..N+2.
- At most one wr_enable bit is high in any cycle, and each enable pulse lasts exactly one cycle per accepted write.
- FIFO full plus a FIFO pop in the same cycle: mem_ready is still 0 that cycle.
- An empty FIFO with a squash is a no-op.
- Squash and push in the same cycle: the squash is applied first, then the push is appended.

## Test plan
- ALU-only path: alu_valid with addr 5 and data 0xDEADBEEF at edge N → wr_enable = 0x00000020 and wr_data = 0xDEADBEEF in the following cycle only.
- Load path: push addr 7 / 0x12345678 with the ALU idle → fifo_count = 1 for one cycle, then wr_enable bit 7 asserted, then fifo_count = 0.
- Full FIFO: push two loads while the ALU is busy every cycle → mem_ready = 0. After STARVE_LIMIT ALU grants, alu_ready = 0 and the head load retires. alu_ready returns to 1 the cycle after the pop.
- Squash: queue a load to addr 9, then grant an ALU write to addr 9 → the load is never committed, fifo_count drops to 0, and the only bit-9 pulse carries the ALU data.
- Register 0: ALU write and load write to addr 0 are both accepted → wr_enable stays 0 and fifo_count returns to 0.
- Reset mid-operation: with the FIFO holding 2 loads, assert reset for one edge → no further wr_enable pulses, fifo_count = 0, mem_ready = 1.
